// File: rtl/riscv_amo_ctrl.sv
// Atomic memory operation sequencer for the LSU: read, modify, write of one
// aligned .W/.D word, with trap abort during the read and a ready timeout.
module riscv_amo_ctrl #(
    parameter int unsigned RDY_TIMEOUT = 255
) (
    input  logic        i_riscv_lsu_clk,
    input  logic        i_riscv_lsu_rst,
    input  logic        i_riscv_amo_valid,
    input  logic [4:0]  i_riscv_amo_funct5,
    input  logic        i_riscv_amo_word,
    input  logic [63:0] i_riscv_amo_addr,
    input  logic [63:0] i_riscv_amo_rs2,
    input  logic        i_riscv_amo_goto_trap,
    input  logic        i_riscv_amo_mem_ready,
    input  logic [63:0] i_riscv_amo_mem_rdata,
    output logic        o_riscv_amo_mem_req,
    output logic        o_riscv_amo_mem_we,
    output logic [63:0] o_riscv_amo_mem_addr,
    output logic [63:0] o_riscv_amo_mem_wdata,
    output logic        o_riscv_amo_stall,
    output logic        o_riscv_amo_done,
    output logic [63:0] o_riscv_amo_rd_value,
    output logic        o_riscv_amo_reserv_kill,
    output logic        o_riscv_amo_misaligned,
    output logic        o_riscv_amo_fault
);

    localparam int unsigned CNT_W = (RDY_TIMEOUT < 1) ? 1 : $clog2(RDY_TIMEOUT + 1);

    localparam logic [4:0] F5_ADD  = 5'b00000;
    localparam logic [4:0] F5_XOR  = 5'b00100;
    localparam logic [4:0] F5_AND  = 5'b01100;
    localparam logic [4:0] F5_OR   = 5'b01000;
    localparam logic [4:0] F5_MIN  = 5'b10000;
    localparam logic [4:0] F5_MAX  = 5'b10100;
    localparam logic [4:0] F5_MINU = 5'b11000;
    localparam logic [4:0] F5_MAXU = 5'b11100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e             state_q,    state_d;
    logic [4:0]         funct5_q,   funct5_d;
    logic               word_q,     word_d;
    logic [63:0]        addr_q,     addr_d;
    logic [63:0]        rs2_q,      rs2_d;
    logic [63:0]        wdata_q,    wdata_d;
    logic [63:0]        rd_value_q, rd_value_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic               fault_q,    fault_d;

    logic               aligned;
    logic [CNT_W-1:0]   cnt_inc;
    logic               timeout;
    logic               signed_cmp;
    logic [63:0]        op_a;
    logic [63:0]        op_b;
    logic               lt_s;
    logic               lt_u;
    logic [63:0]        res;
    logic [63:0]        amo_wdata;

    assign aligned = i_riscv_amo_word ? (i_riscv_amo_addr[1:0] == 2'b00)
                                      : (i_riscv_amo_addr[2:0] == 3'b000);
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign timeout = (cnt_inc == CNT_W'(RDY_TIMEOUT));

    // .W operands are extended to 64 bits so one comparator serves both widths
    assign signed_cmp = (funct5_q == F5_MIN) || (funct5_q == F5_MAX);
    assign op_a = !word_q ? i_riscv_amo_mem_rdata
                : signed_cmp ? {{32{i_riscv_amo_mem_rdata[31]}}, i_riscv_amo_mem_rdata[31:0]}
                : {32'b0, i_riscv_amo_mem_rdata[31:0]};
    assign op_b = !word_q ? rs2_q
                : signed_cmp ? {{32{rs2_q[31]}}, rs2_q[31:0]}
                : {32'b0, rs2_q[31:0]};
    assign lt_s = $signed(op_a) < $signed(op_b);
    assign lt_u = op_a < op_b;

    always_comb begin
        res = op_b;
        case (funct5_q)
            F5_ADD:  res = op_a + op_b;
            F5_XOR:  res = op_a ^ op_b;
            F5_AND:  res = op_a & op_b;
            F5_OR:   res = op_a | op_b;
            F5_MIN:  res = lt_s ? op_a : op_b;
            F5_MAX:  res = lt_s ? op_b : op_a;
            F5_MINU: res = lt_u ? op_a : op_b;
            F5_MAXU: res = lt_u ? op_b : op_a;
            default: res = op_b;
        endcase
    end

    assign amo_wdata = word_q ? {32'b0, res[31:0]} : res;

    // Next-state and latch logic
    always_comb begin
        state_d    = state_q;
        funct5_d   = funct5_q;
        word_d     = word_q;
        addr_d     = addr_q;
        rs2_d      = rs2_q;
        wdata_d    = wdata_q;
        rd_value_d = rd_value_q;
        cnt_d      = cnt_q;
        fault_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_riscv_amo_valid && !i_riscv_amo_goto_trap && aligned) begin
                    state_d  = ST_READ;
                    funct5_d = i_riscv_amo_funct5;
                    word_d   = i_riscv_amo_word;
                    addr_d   = i_riscv_amo_addr;
                    rs2_d    = i_riscv_amo_rs2;
                    cnt_d    = '0;
                end
            end
            ST_READ: begin
                if (i_riscv_amo_goto_trap) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (i_riscv_amo_mem_ready) begin
                    state_d    = ST_WRITE;
                    rd_value_d = word_q ? {{32{i_riscv_amo_mem_rdata[31]}}, i_riscv_amo_mem_rdata[31:0]}
                                        : i_riscv_amo_mem_rdata;
                    wdata_d    = amo_wdata;
                    cnt_d      = '0;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                    fault_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_WRITE: begin
                if (i_riscv_amo_mem_ready) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                    fault_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_riscv_lsu_clk or posedge i_riscv_lsu_rst) begin
        if (i_riscv_lsu_rst) begin
            state_q    <= ST_IDLE;
            funct5_q   <= '0;
            word_q     <= 1'b0;
            addr_q     <= '0;
            rs2_q      <= '0;
            wdata_q    <= '0;
            rd_value_q <= '0;
            cnt_q      <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            funct5_q   <= funct5_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            rs2_q      <= rs2_d;
            wdata_q    <= wdata_d;
            rd_value_q <= rd_value_d;
            cnt_q      <= cnt_d;
            fault_q    <= fault_d;
        end
    end

    // Memory side is decoded from state flops so reset drops req at once
    assign o_riscv_amo_mem_req   = (state_q == ST_READ) || (state_q == ST_WRITE);
    assign o_riscv_amo_mem_we    = (state_q == ST_WRITE);
    assign o_riscv_amo_mem_addr  = o_riscv_amo_mem_req ? addr_q : 64'd0;
    assign o_riscv_amo_mem_wdata = (state_q == ST_WRITE) ? wdata_q : 64'd0;

    // Input-dependent IDLE terms are masked during reset to keep outputs at 0
    assign o_riscv_amo_stall = ((state_q == ST_IDLE) && !i_riscv_lsu_rst && i_riscv_amo_valid
                                && aligned && !i_riscv_amo_goto_trap)
                             || (state_q == ST_READ) || (state_q == ST_WRITE);
    assign o_riscv_amo_misaligned = (state_q == ST_IDLE) && !i_riscv_lsu_rst
                                  && i_riscv_amo_valid && !aligned;
    assign o_riscv_amo_reserv_kill = (state_q == ST_WRITE) && i_riscv_amo_mem_ready;
    assign o_riscv_amo_done        = (state_q == ST_DONE);
    assign o_riscv_amo_rd_value    = rd_value_q;
    assign o_riscv_amo_fault       = fault_q;

endmodule

// File: tb/tb_riscv_amo_ctrl.sv
// Directed self-checking bench for riscv_amo_ctrl with a short ready timeout.
module tb_riscv_amo_ctrl;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [4:0]  funct5;
    logic        word;
    logic [63:0] addr;
    logic [63:0] rs2;
    logic        trap;
    logic        ready;
    logic [63:0] rdata;
    logic        req;
    logic        we;
    logic [63:0] maddr;
    logic [63:0] wdata;
    logic        stall;
    logic        done;
    logic [63:0] rd_value;
    logic        kill;
    logic        misaligned;
    logic        fault;

    int checks = 0;
    int errors = 0;

    riscv_amo_ctrl #(.RDY_TIMEOUT(4)) dut (
        .i_riscv_lsu_clk        (clk),
        .i_riscv_lsu_rst        (rst),
        .i_riscv_amo_valid      (valid),
        .i_riscv_amo_funct5     (funct5),
        .i_riscv_amo_word       (word),
        .i_riscv_amo_addr       (addr),
        .i_riscv_amo_rs2        (rs2),
        .i_riscv_amo_goto_trap  (trap),
        .i_riscv_amo_mem_ready  (ready),
        .i_riscv_amo_mem_rdata  (rdata),
        .o_riscv_amo_mem_req    (req),
        .o_riscv_amo_mem_we     (we),
        .o_riscv_amo_mem_addr   (maddr),
        .o_riscv_amo_mem_wdata  (wdata),
        .o_riscv_amo_stall      (stall),
        .o_riscv_amo_done       (done),
        .o_riscv_amo_rd_value   (rd_value),
        .o_riscv_amo_reserv_kill(kill),
        .o_riscv_amo_misaligned (misaligned),
        .o_riscv_amo_fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the falling edge; checks follow 1 time unit later
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic run_amo(input string tag, input logic [4:0] f5, input logic w,
                           input logic [63:0] a, input logic [63:0] s2, input logic [63:0] rd,
                           input logic [63:0] exp_wd, input logic [63:0] exp_rd);
        tick();
        valid = 1'b1; funct5 = f5; word = w; addr = a; rs2 = s2; rdata = rd; ready = 1'b1;
        #1;
        chk({tag, "_c0_stall"}, 64'(stall), 64'd1);
        chk({tag, "_c0_req"},   64'(req),   64'd0);
        tick();
        valid = 1'b0;
        #1;
        chk({tag, "_rd_req"},  64'(req), 64'd1);
        chk({tag, "_rd_we"},   64'(we),  64'd0);
        chk({tag, "_rd_addr"}, maddr,    a);
        tick();
        #1;
        chk({tag, "_wr_we"},    64'(we),   64'd1);
        chk({tag, "_wr_wdata"}, wdata,     exp_wd);
        chk({tag, "_wr_kill"},  64'(kill), 64'd1);
        tick();
        #1;
        chk({tag, "_done"},      64'(done),  64'd1);
        chk({tag, "_rd_value"},  rd_value,   exp_rd);
        chk({tag, "_done_req"},  64'(req),   64'd0);
        chk({tag, "_done_stall"},64'(stall), 64'd0);
        chk({tag, "_done_kill"}, 64'(kill),  64'd0);
        tick();
        #1;
        chk({tag, "_idle_done"}, 64'(done), 64'd0);
        chk({tag, "_idle_hold"}, rd_value,  exp_rd);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; funct5 = 5'd0; word = 1'b0; addr = 64'd0;
        rs2 = 64'd0; trap = 1'b0; ready = 1'b0; rdata = 64'd0;
        tick(); tick();
        valid = 1'b1; addr = 64'h1003;
        #1;
        chk("rst_req",        64'(req),        64'd0);
        chk("rst_stall",      64'(stall),      64'd0);
        chk("rst_done",       64'(done),       64'd0);
        chk("rst_rd_value",   rd_value,        64'd0);
        chk("rst_fault",      64'(fault),      64'd0);
        chk("rst_misaligned", 64'(misaligned), 64'd0);
        chk("rst_wdata",      wdata,           64'd0);
        tick();
        rst = 1'b0; valid = 1'b0; addr = 64'd0;

        run_amo("add_d",  5'b00000, 1'b0, 64'h1000, 64'd3, 64'd5, 64'd8, 64'd5);
        run_amo("min_w",  5'b10000, 1'b1, 64'h2000, 64'd1, 64'h12345678_FFFFFFFE,
                64'h00000000_FFFFFFFE, 64'hFFFFFFFF_FFFFFFFE);
        run_amo("add_w_wrap", 5'b00000, 1'b1, 64'h2004, 64'd2, 64'h00000000_FFFFFFFF,
                64'h00000000_00000001, 64'hFFFFFFFF_FFFFFFFF);
        run_amo("maxu_w", 5'b11100, 1'b1, 64'h2008, 64'd1, 64'h00000000_FFFFFFFE,
                64'h00000000_FFFFFFFE, 64'hFFFFFFFF_FFFFFFFE);
        run_amo("max_d",  5'b10100, 1'b0, 64'h2010, 64'h8000000000000000, 64'd7, 64'd7, 64'd7);
        run_amo("and_d",  5'b01100, 1'b0, 64'h2018, 64'hFF00FF00FF00FF00,
                64'hF0F0F0F0F0F0F0F0, 64'hF000F000F000F000, 64'hF0F0F0F0F0F0F0F0);
        run_amo("bad_f5_swap", 5'b00010, 1'b0, 64'h2020, 64'hDEADBEEFCAFEF00D,
                64'd1, 64'hDEADBEEFCAFEF00D, 64'd1);

        // Misaligned .D: one-cycle flag, no request, no stall
        tick();
        valid = 1'b1; funct5 = 5'b11100; word = 1'b0; addr = 64'h1004;
        #1;
        chk("mis_flag",  64'(misaligned), 64'd1);
        chk("mis_stall", 64'(stall),      64'd0);
        chk("mis_req",   64'(req),        64'd0);
        tick();
        valid = 1'b0;
        #1;
        chk("mis_flag_off", 64'(misaligned), 64'd0);
        chk("mis_req_off",  64'(req),        64'd0);

        // Trap in IDLE blocks the start
        tick();
        valid = 1'b1; addr = 64'h1000; trap = 1'b1;
        #1;
        chk("trap_idle_stall", 64'(stall), 64'd0);
        tick();
        valid = 1'b0; trap = 1'b0;
        #1;
        chk("trap_idle_req", 64'(req), 64'd0);

        // Ready timeout in READ: four wait cycles then fault
        tick();
        valid = 1'b1; funct5 = 5'b00000; word = 1'b0; addr = 64'h3000; ready = 1'b0;
        tick();
        valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("to_wait_req",  64'(req), 64'd1);
            chk("to_wait_addr", maddr,    64'h3000);
            chk("to_wait_fault",64'(fault), 64'd0);
            tick();
        end
        #1;
        chk("to_fault", 64'(fault), 64'd1);
        chk("to_req",   64'(req),   64'd0);
        chk("to_stall", 64'(stall), 64'd0);
        chk("to_done",  64'(done),  64'd0);
        tick();
        #1;
        chk("to_fault_off", 64'(fault), 64'd0);
        chk("to_no_done",   64'(done),  64'd0);

        // Trap in READ aborts without write
        tick();
        valid = 1'b1; addr = 64'h4000; ready = 1'b0;
        tick();
        valid = 1'b0; trap = 1'b1;
        #1;
        chk("trap_rd_req", 64'(req), 64'd1);
        tick();
        trap = 1'b0;
        #1;
        chk("trap_rd_abort_req", 64'(req),  64'd0);
        chk("trap_rd_abort_we",  64'(we),   64'd0);
        chk("trap_rd_no_done",   64'(done), 64'd0);
        tick();
        #1;
        chk("trap_rd_no_done2", 64'(done), 64'd0);
        chk("trap_rd_req2",     64'(req),  64'd0);

        // Trap in WRITE is ignored
        tick();
        valid = 1'b1; funct5 = 5'b00100; addr = 64'h4008; rs2 = 64'h0F; rdata = 64'hF0; ready = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        trap = 1'b1;
        #1;
        chk("trap_wr_we",    64'(we), 64'd1);
        chk("trap_wr_wdata", wdata,   64'hFF);
        tick();
        #1;
        chk("trap_wr_done", 64'(done), 64'd1);
        chk("trap_wr_rd",   rd_value,  64'hF0);
        tick();
        trap = 1'b0;

        // Reset while waiting in WRITE
        tick();
        valid = 1'b1; funct5 = 5'b00000; addr = 64'h5000; rs2 = 64'd1; rdata = 64'h77; ready = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        ready = 1'b0;
        #1;
        chk("rw_in_write", 64'(we), 64'd1);
        chk("rw_rd_pre",   rd_value, 64'h77);
        tick();
        rst = 1'b1;
        #1;
        chk("rw_req",   64'(req),   64'd0);
        chk("rw_we",    64'(we),    64'd0);
        chk("rw_stall", 64'(stall), 64'd0);
        chk("rw_rd",    rd_value,   64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rw_post_req", 64'(req), 64'd0);
        tick();
        #1;
        chk("rw_post_done", 64'(done), 64'd0);
        chk("rw_post_req2", 64'(req),  64'd0);

        run_amo("or_d_recover", 5'b01000, 1'b0, 64'h6000, 64'h0F, 64'hF0, 64'hFF, 64'hF0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
